// File: rtl/tx_gearbox.sv
// Transmit 66b->32b gearbox: packs 66-bit blocks into 32-bit serializer words, inserting idles on starvation.
// Optional TX_SCRAMBLER_EN adds a self-synchronous x^58+x^39+1 payload scrambler.
module tx_gearbox (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [65:0] block_i,
  input  logic        block_valid_i,
  output logic        block_ready_o,
  output logic [31:0] tx_data_o,
  output logic        tx_valid_o,
  output logic [5:0]  gbox_cnt_o,
  output logic        idle_ins_o
);

  localparam logic [65:0] IDLE_BLK = {2'b10, 64'h7800_0000_0000_0000};

  logic [95:0] res_q, res_d, fill;
  logic [6:0]  occ_q, occ_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        vld_q, idle_q, idle_d;
  logic        load;
  logic [65:0] blk_raw, blk;

  assign load    = (occ_q < 7'd32);
  assign blk_raw = block_valid_i ? block_i : IDLE_BLK;

`ifdef TX_SCRAMBLER_EN
  logic [57:0] scr_q, scr_d;
  logic [63:0] pay_s;

  // Serial scrambler unrolled over the payload, MSB (first transmitted) first.
  always_comb begin
    scr_d = scr_q;
    pay_s = '0;
    for (int k = 0; k < 64; k++) begin
      pay_s[63-k] = blk_raw[63-k] ^ scr_d[38] ^ scr_d[57];
      scr_d       = {scr_d[56:0], pay_s[63-k]};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     scr_q <= '0;
    else if (load) scr_q <= scr_d;
  end

  assign blk = {blk_raw[65:64], pay_s};
`else
  assign blk = blk_raw;
`endif

  always_comb begin
    fill = res_q;
    // New block lands directly below the occ valid residue bits.
    if (load) fill = res_q | ({blk, 30'b0} >> occ_q);
    data_d = fill[95:64];
    res_d  = {fill[63:0], 32'b0};
    occ_d  = load ? (occ_q + 7'd66 - 7'd32) : (occ_q - 7'd32);
    cnt_d  = (cnt_q == 6'd32) ? 6'd0 : cnt_q + 6'd1;
    idle_d = load && !block_valid_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_q  <= '0;
      occ_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
      idle_q <= 1'b0;
    end else begin
      res_q  <= res_d;
      occ_q  <= occ_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      vld_q  <= 1'b1;
      idle_q <= idle_d;
    end
  end

  assign block_ready_o = load;
  assign tx_data_o     = data_q;
  assign tx_valid_o    = vld_q;
  assign gbox_cnt_o    = cnt_q;
  assign idle_ins_o    = idle_q;

endmodule

// File: tb/tb_tx_gearbox.sv
// Bench for tx_gearbox: bit-level scoreboard of the transmitted stream plus phase/ready/idle tracking.
module tb_tx_gearbox;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [65:0] blk = '0;
  logic        bv  = 1'b0;
  logic        rdy_o, vld_o, idle_o;
  logic [31:0] data_o;
  logic [5:0]  cnt_o;

  localparam logic [65:0] IDLE = {2'b10, 64'h7800_0000_0000_0000};

  tx_gearbox dut (
    .clk_i(clk), .rst_i(rst), .block_i(blk), .block_valid_i(bv),
    .block_ready_o(rdy_o), .tx_data_o(data_o), .tx_valid_o(vld_o),
    .gbox_cnt_o(cnt_o), .idle_ins_o(idle_o)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  bit          bq[$];
  int          exp_cnt = 0;
  logic [57:0] msc = '0;

  task automatic chk(input string tag, input logic [65:0] act, input logic [65:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    bq.delete();
    exp_cnt = 0;
    msc = '0;
  endtask

  task automatic push_blk(input logic [65:0] b);
    logic [65:0] x;
    x = b;
`ifdef TX_SCRAMBLER_EN
    for (int i = 63; i >= 0; i--) begin
      x[i] = b[i] ^ msc[38] ^ msc[57];
      msc  = {msc[56:0], x[i]};
    end
`endif
    for (int i = 65; i >= 0; i--) bq.push_back(x[i]);
  endtask

  // One clock: check ready, feed the scoreboard, then compare the emitted word.
  task automatic cyc(output bit acc);
    bit rdy, v;
    logic [31:0] w;
    rdy = (exp_cnt % 2 == 0) && (exp_cnt != 32);
    v   = bv;
    chk("ready", rdy_o, rdy);
    acc = rdy && v;
    if (rdy) push_blk(v ? blk : IDLE);
    @(posedge clk); #1;
    exp_cnt = (exp_cnt == 32) ? 0 : exp_cnt + 1;
    w = '0;
    if (bq.size() < 32) chk("underrun", bq.size(), 32);
    else for (int i = 0; i < 32; i++) w = {w[30:0], bq.pop_front()};
    chk("data", data_o, w);
    chk("valid", vld_o, 1);
    chk("idle", idle_o, rdy && !v);
    chk("cnt", cnt_o, exp_cnt);
  endtask

  task automatic do_reset();
    bv  = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bit a;
    int n;
    bit found;
    logic [31:0] w0, w1, w2;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", data_o, 0);
    chk("rst_valid", vld_o, 0);
    chk("rst_ready", rdy_o, 1);
    chk("rst_cnt", cnt_o, 0);
    chk("rst_idle", idle_o, 0);
    rst = 1'b0;
    model_reset();

    // Single block then starvation
    blk = {2'b01, {64{1'b1}}};
    bv  = 1'b1;
    cyc(a);
    chk("acc_first", a, 1);
`ifndef TX_SCRAMBLER_EN
    chk("w0", data_o, 32'h7FFF_FFFF);
`endif
    bv = 1'b0;
    cyc(a);
`ifndef TX_SCRAMBLER_EN
    chk("w1", data_o, 32'hFFFF_FFFF);
`endif
    cyc(a);
    chk("idle_pulse", idle_o, 1);
    repeat (10) cyc(a);

    // Continuous valid, incrementing payload
    do_reset();
    n  = 0;
    bv = 1'b1;
    for (int i = 0; i < 66; i++) begin
      blk = {2'b01, 64'h1000 + 64'(n)};
      cyc(a);
      if (a) n++;
    end
    chk("blocks66", n, 32);

    // Valid toggling every third cycle; block held until accepted
    n = 0;
    for (int i = 0; i < 99; i++) begin
      bv  = ((i / 3) % 2 == 0);
      blk = {(n % 4 == 0) ? 2'b10 : 2'b01, 64'hDEAD_0000_0000_0000 ^ (64'(n) * 64'h0001_0203_0405_0607)};
      cyc(a);
      if (a) n++;
    end
    bv = 1'b0;
    repeat (4) cyc(a);

    // Asynchronous reset at phase 17
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (cnt_o == 6'd17) found = 1'b1;
      else cyc(a);
    end
    chk("find17", found, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_data", data_o, 0);
    chk("arst_valid", vld_o, 0);
    chk("arst_cnt", cnt_o, 0);
    chk("arst_ready", rdy_o, 1);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    blk = {2'b01, 64'hA5C3_0F96_1234_5678};
    bv  = 1'b1;
    cyc(a);
    chk("post_rst_acc", a, 1);
`ifndef TX_SCRAMBLER_EN
    chk("post_rst_w0", data_o, blk[65:34]);
`endif
    chk("post_rst_cnt", cnt_o, 1);
    bv = 1'b0;
    repeat (6) cyc(a);

`ifdef TX_SCRAMBLER_EN
    do_reset();
    blk = {2'b01, 64'h8000_0000_0000_0000};
    bv  = 1'b1;
    cyc(a);
    w0 = data_o;
    bv = 1'b0;
    cyc(a);
    w1 = data_o;
    cyc(a);
    w2 = data_o;
    chk("scr_block", {w0, w1, w2[31:30]}, {2'b01, 64'h8000_0000_0100_0020});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
